// File: rtl/codec_init_sequencer.sv
// ============================================================================
// Module      : codec_init_sequencer
// Description : Walks a parameterised table of codec register writes through an
//               I2C byte controller, with pausing between writes and NACK retry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module codec_init_sequencer #(
  parameter int                   NUM_REGS     = 8,
  parameter logic [6:0]           PERIPH_ADDR  = 7'b0011010,
  parameter int                   PAUSE_CYCLES = 1000,
  parameter int                   MAX_RETRIES  = 3,
  parameter logic [NUM_REGS*16-1:0] INIT_TABLE = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [6:0] cmd_addr,
  output logic [7:0] cmd_byte0,
  output logic [7:0] cmd_byte1,
  input  logic       xfer_done,
  input  logic       xfer_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] fail_index,
  output logic [3:0] state_info
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_ISSUE = 4'd2,
    S_WAIT  = 4'd3,
    S_PAUSE = 4'd4,
    S_DONE  = 4'd14,
    S_ERROR = 4'd15
  } state_t;

  localparam int             PCW        = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [PCW-1:0] PAUSE_LOAD = (PAUSE_CYCLES > 0) ? PCW'(PAUSE_CYCLES - 1) : '0;
  localparam logic [7:0]     LAST_IDX   = 8'(NUM_REGS - 1);
  localparam logic [3:0]     RETRY_MAX  = 4'(MAX_RETRIES);

  state_t         state_q, state_d;
  logic [7:0]     index_q, index_d;
  logic [3:0]     retry_q, retry_d;
  logic [PCW-1:0] pause_q, pause_d;
  logic [7:0]     byte0_q, byte0_d;
  logic [7:0]     byte1_q, byte1_d;
  logic [7:0]     fail_q,  fail_d;
  logic [15:0]    entry_w;

  // Constant-width compare per entry keeps the table select free of width
  // mismatches for any NUM_REGS.
  always_comb begin
    entry_w = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (index_q == 8'(i)) begin
        entry_w = INIT_TABLE[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      retry_q <= '0;
      pause_q <= '0;
      byte0_q <= '0;
      byte1_q <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      retry_q <= retry_d;
      pause_q <= pause_d;
      byte0_q <= byte0_d;
      byte1_q <= byte1_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    retry_d = retry_q;
    pause_d = pause_q;
    byte0_d = byte0_q;
    byte1_d = byte1_q;
    fail_d  = fail_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          index_d = '0;
          retry_d = '0;
        end
      end

      S_LOAD: begin
        byte0_d = {entry_w[15:9], entry_w[8]};
        byte1_d = entry_w[7:0];
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        if (cmd_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (xfer_done) begin
          if (!xfer_nack && (index_q == LAST_IDX)) begin
            state_d = S_DONE;
          end else if (xfer_nack && (retry_q == RETRY_MAX)) begin
            state_d = S_ERROR;
            fail_d  = index_q;
          end else begin
            if (xfer_nack) begin
              retry_d = retry_q + 4'd1;
            end else begin
              index_d = index_q + 8'd1;
              retry_d = '0;
            end
            // With no pause configured the next attempt loads immediately.
            if (PAUSE_CYCLES == 0) begin
              state_d = S_LOAD;
            end else begin
              state_d = S_PAUSE;
              pause_d = PAUSE_LOAD;
            end
          end
        end
      end

      S_PAUSE: begin
        if (pause_q == '0) begin
          state_d = S_LOAD;
        end else begin
          pause_d = pause_q - 1'b1;
        end
      end

      S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          index_d = '0;
          retry_d = '0;
          fail_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_valid  = (state_q == S_ISSUE);
  assign cmd_addr   = PERIPH_ADDR;
  assign cmd_byte0  = byte0_q;
  assign cmd_byte1  = byte1_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign fail_index = fail_q;
  assign state_info = state_q;

endmodule

`default_nettype wire
